// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - round-robin sequencer/arbiter for a bank of level-sensitive JK latch cells
module jk_bank_ctrl #(
    parameter int  WIDTH      = 8,
    parameter int  NREQ       = 4,
    parameter int  AW         = 3,
    parameter int  STROBE_CYC = 1,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [AW*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic                 done_valid,
    output logic [IDW-1:0]       done_id,
    output logic                 done_err,
    output logic [WIDTH-1:0]     lat_j,
    output logic [WIDTH-1:0]     lat_k,
    output logic [WIDTH-1:0]     lat_en,
    output logic [WIDTH-1:0]     shadow_q,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    state_t            state_q;
    state_t            state_n;
    logic              init_mode_q;
    logic [AW-1:0]     init_addr_q;
    logic [AW-1:0]     cur_addr_q;
    logic              cur_set_q;
    logic              cur_err_q;
    logic [IDW-1:0]    cur_id_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [3:0]        cnt_q;

    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [1:0]        g_op;
    logic [AW-1:0]     g_addr;
    logic              g_shadow_bit;
    logic              g_err;
    logic              g_set;
    logic              g_noop;
    logic              accept;

    logic [AW-1:0]     act_addr;
    logic              act_set;
    logic              drive;
    logic [WIDTH-1:0]  sel;
    logic [WIDTH-1:0]  j_c;
    logic [WIDTH-1:0]  k_c;

    // Round-robin search starting at rr_ptr, plus decode of the winner's command.
    always_comb begin
        grant_found  = 1'b0;
        grant_id     = '0;
        g_op         = OP_HOLD;
        g_addr       = '0;
        g_shadow_bit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && (i == (int'(rr_ptr_q) + k) % NREQ) && req_valid[i]) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                g_op   = req_op[2*i +: 2];
                g_addr = req_addr[AW*i +: AW];
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (g_addr == AW'(i)) begin
                g_shadow_bit = shadow_q[i];
            end
        end
        // Toggle is resolved against the shadow so the cell never sees j=k=1.
        g_err  = (int'(g_addr) >= WIDTH);
        g_set  = (g_op == OP_SET) || ((g_op == OP_TOGGLE) && !g_shadow_bit);
        g_noop = g_err || (g_op == OP_HOLD);
        accept = (state_q == ST_IDLE) && grant_found;
    end

    // Next-state logic for the operation sequencer (INIT reuses STROBE/HOLD).
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_INIT:   state_n = ST_STROBE;
            ST_IDLE:   if (grant_found) state_n = g_noop ? ST_DONE : ST_SETUP;
            ST_SETUP:  state_n = ST_STROBE;
            ST_STROBE: if (cnt_q == 4'd0) state_n = ST_HOLD;
            ST_HOLD: begin
                if (!init_mode_q) begin
                    state_n = ST_DONE;
                end else if (init_addr_q == AW'(WIDTH - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_INIT;
                end
            end
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_INIT;
        endcase
    end

    // Cell drive decode: j/k cover SETUP..HOLD, enable only during STROBE.
    always_comb begin
        act_addr = init_mode_q ? init_addr_q : cur_addr_q;
        act_set  = init_mode_q ? 1'b0 : cur_set_q;
        drive    = (state_q == ST_INIT) || (state_q == ST_SETUP) ||
                   (state_q == ST_STROBE) || (state_q == ST_HOLD);
        sel      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (act_addr == AW'(i)) begin
                sel[i] = 1'b1;
            end
        end
        j_c = (drive && act_set)  ? sel : '0;
        k_c = (drive && !act_set) ? sel : '0;
    end

    // Outputs; j/k are held quiet while reset is asserted even though the state sits in INIT.
    always_comb begin
        lat_j      = j_c & {WIDTH{rst_n}};
        lat_k      = k_c & {WIDTH{rst_n}};
        lat_en     = (state_q == ST_STROBE) ? sel : '0;
        done_valid = (state_q == ST_DONE);
        done_id    = (state_q == ST_DONE) ? cur_id_q : '0;
        done_err   = (state_q == ST_DONE) && cur_err_q;
        busy       = (state_q != ST_IDLE);
        req_ready  = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // State, captured command, strobe counter, init walk and shadow copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_mode_q <= 1'b1;
            init_addr_q <= '0;
            cur_addr_q  <= '0;
            cur_set_q   <= 1'b0;
            cur_err_q   <= 1'b0;
            cur_id_q    <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                cur_addr_q <= g_addr;
                cur_set_q  <= g_set;
                cur_err_q  <= g_err;
                cur_id_q   <= grant_id;
                rr_ptr_q   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            if ((state_n == ST_STROBE) && (state_q != ST_STROBE)) begin
                cnt_q <= 4'(STROBE_CYC - 1);
            end else if ((state_q == ST_STROBE) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if ((state_q == ST_HOLD) && init_mode_q) begin
                if (init_addr_q == AW'(WIDTH - 1)) begin
                    init_mode_q <= 1'b0;
                end else begin
                    init_addr_q <= init_addr_q + AW'(1);
                end
            end
            if ((state_q == ST_HOLD) && !init_mode_q) begin
                shadow_q <= (shadow_q & ~sel) | (cur_set_q ? sel : '0);
            end
        end
    end

    a_jk_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        ((lat_j & lat_k) == '0));
    a_only_addressed: assert property (@(posedge clk) disable iff (!rst_n)
        (((lat_j | lat_k | lat_en) & ~sel) == '0));
    a_en_in_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q != ST_STROBE) |-> (lat_en == '0)));

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb/tb_jk_bank_ctrl.sv - directed self-checking bench for jk_bank_ctrl
module tb_jk_bank_ctrl;

    localparam int WIDTH      = 8;
    localparam int NREQ       = 4;
    localparam int AW         = 4;
    localparam int STROBE_CYC = 1;
    localparam int INIT_CYC   = WIDTH * (STROBE_CYC + 2);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_op;
    logic [AW*NREQ-1:0]  req_addr;
    logic [NREQ-1:0]     req_ready;
    logic                done_valid;
    logic [1:0]          done_id;
    logic                done_err;
    logic [WIDTH-1:0]    lat_j;
    logic [WIDTH-1:0]    lat_k;
    logic [WIDTH-1:0]    lat_en;
    logic [WIDTH-1:0]    shadow_q;
    logic                busy;

    int errors = 0;
    int checks = 0;

    jk_bank_ctrl #(
        .WIDTH(WIDTH), .NREQ(NREQ), .AW(AW), .STROBE_CYC(STROBE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_ready(req_ready),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .lat_j(lat_j), .lat_k(lat_k), .lat_en(lat_en),
        .shadow_q(shadow_q), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [AW-1:0] addr);
        req_valid[i]          = 1'b1;
        req_op[2*i +: 2]      = op;
        req_addr[AW*i +: AW]  = addr;
    endtask

    task automatic init_check();
        for (int c = 0; c < INIT_CYC; c++) begin
            chk("init_busy", 32'(busy), 32'h1);
            chk("init_k", 32'(lat_k), 32'h1 << (c / 3));
            chk("init_j", 32'(lat_j), 32'h0);
            chk("init_en", 32'(lat_en), ((c % 3) == 1) ? (32'h1 << (c / 3)) : 32'h0);
            chk("init_ready", 32'(req_ready), 32'h0);
            chk("init_done", 32'(done_valid), 32'h0);
            cyc();
        end
        chk("init_end_busy", 32'(busy), 32'h0);
        chk("init_end_shadow", 32'(shadow_q), 32'h0);
        chk("init_end_k", 32'(lat_k), 32'h0);
    endtask

    // Cell-safety monitor while out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("mon_jk_excl", 32'(lat_j & lat_k), 32'h0);
            chk("mon_en_drive", 32'(lat_en & ~(lat_j | lat_k)), 32'h0);
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_addr  = '0;
        repeat (3) cyc();
        chk("rst_en", 32'(lat_en), 32'h0);
        chk("rst_j", 32'(lat_j), 32'h0);
        chk("rst_k", 32'(lat_k), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_done", 32'(done_valid), 32'h0);
        chk("rst_shadow", 32'(shadow_q), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        init_check();

        // Requester 2: set cell 5
        set_req(2, 2'b10, 4'd5);
        #1;
        chk("set_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        #1;
        chk("set_setup_j", 32'(lat_j), 32'h20);
        chk("set_setup_k", 32'(lat_k), 32'h0);
        chk("set_setup_en", 32'(lat_en), 32'h0);
        chk("set_setup_ready", 32'(req_ready), 32'h0);
        chk("set_setup_busy", 32'(busy), 32'h1);
        cyc();
        chk("set_strobe_en", 32'(lat_en), 32'h20);
        chk("set_strobe_j", 32'(lat_j), 32'h20);
        cyc();
        chk("set_hold_en", 32'(lat_en), 32'h0);
        chk("set_hold_j", 32'(lat_j), 32'h20);
        chk("set_hold_done", 32'(done_valid), 32'h0);
        chk("set_hold_shadow", 32'(shadow_q), 32'h0);
        cyc();
        chk("set_done_valid", 32'(done_valid), 32'h1);
        chk("set_done_id", 32'(done_id), 32'h2);
        chk("set_done_err", 32'(done_err), 32'h0);
        chk("set_done_j", 32'(lat_j), 32'h0);
        chk("set_shadow", 32'(shadow_q), 32'h20);
        cyc();
        chk("set_idle_done", 32'(done_valid), 32'h0);
        chk("set_idle_busy", 32'(busy), 32'h0);

        // Requester 0: toggle cell 5 (resolves to reset)
        set_req(0, 2'b11, 4'd5);
        #1;
        chk("tog1_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        #1;
        chk("tog1_setup_k", 32'(lat_k), 32'h20);
        chk("tog1_setup_j", 32'(lat_j), 32'h0);
        cyc();
        chk("tog1_strobe_en", 32'(lat_en), 32'h20);
        chk("tog1_strobe_k", 32'(lat_k), 32'h20);
        cyc();
        cyc();
        chk("tog1_done_id", 32'(done_id), 32'h0);
        chk("tog1_shadow", 32'(shadow_q), 32'h0);
        cyc();

        // Requester 0 again: toggle cell 5 (resolves to set)
        set_req(0, 2'b11, 4'd5);
        #1;
        chk("tog2_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        #1;
        chk("tog2_setup_j", 32'(lat_j), 32'h20);
        chk("tog2_setup_k", 32'(lat_k), 32'h0);
        cyc();
        cyc();
        cyc();
        chk("tog2_done", 32'(done_valid), 32'h1);
        chk("tog2_shadow", 32'(shadow_q), 32'h20);
        cyc();

        // Requester 1: set at out-of-range address 9
        set_req(1, 2'b10, 4'd9);
        #1;
        chk("err_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        #1;
        chk("err_done_valid", 32'(done_valid), 32'h1);
        chk("err_done_err", 32'(done_err), 32'h1);
        chk("err_done_id", 32'(done_id), 32'h1);
        chk("err_en", 32'(lat_en), 32'h0);
        chk("err_shadow", 32'(shadow_q), 32'h20);
        cyc();
        chk("err_idle_done", 32'(done_valid), 32'h0);

        // Requester 3: hold, brings rr_ptr back to 0
        set_req(3, 2'b00, 4'd0);
        #1;
        chk("hold_ready", 32'(req_ready), 32'h8);
        cyc();
        req_valid = '0;
        #1;
        chk("hold_done_id", 32'(done_id), 32'h3);
        chk("hold_done_err", 32'(done_err), 32'h0);
        cyc();

        // All four requesters valid with hold ops: grants 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 4'd0);
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'h1 << (n % 4));
            chk("rr_idle_busy", 32'(busy), 32'h0);
            cyc();
            chk("rr_done_valid", 32'(done_valid), 32'h1);
            chk("rr_done_id", 32'(done_id), 32'(n % 4));
            chk("rr_done_ready", 32'(req_ready), 32'h0);
            cyc();
        end
        req_valid = '0;
        #1;

        // Requester 1 (rr_ptr=1): set cell 3, reset asserted mid-STROBE
        set_req(1, 2'b10, 4'd3);
        #1;
        chk("abort_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        #1;
        chk("abort_setup_j", 32'(lat_j), 32'h08);
        cyc();
        chk("abort_strobe_en", 32'(lat_en), 32'h08);
        rst_n = 1'b0;
        #1;
        chk("abort_en_drop", 32'(lat_en), 32'h0);
        chk("abort_j_drop", 32'(lat_j), 32'h0);
        chk("abort_shadow", 32'(shadow_q), 32'h0);
        chk("abort_done", 32'(done_valid), 32'h0);
        req_valid = '1;
        cyc();
        chk("abort_rst_done", 32'(done_valid), 32'h0);
        cyc();
        chk("abort_rst_done2", 32'(done_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        init_check();
        chk("post_init_ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
